// File: rtl/conv_rlt_collect_pkg.sv
// Shared types and default geometry for the convolution result collector.
// The FIFO entry layout is {data,row,col}, with the window sum in the upper bits.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_WEIGHT_WIDTH  = 2;
  localparam int DEF_WEIGHT_HEIGHT = 2;
  localparam int DEF_RESULT_WIDTH  = 3;
  localparam int DEF_RESULT_HEIGHT = 3;
  localparam int DEF_BITWIDTH      = 3;
  localparam int DEF_ACC_WIDTH     = 2 * DEF_BITWIDTH + 4;
  localparam int DEF_FIFO_DEPTH    = 4;

  localparam int TAPS = DEF_WEIGHT_WIDTH * DEF_WEIGHT_HEIGHT;
  localparam int NRES = DEF_RESULT_WIDTH * DEF_RESULT_HEIGHT;

  typedef struct packed {
    logic signed [DEF_ACC_WIDTH-1:0] data;
    logic [3:0]                      row;
    logic [3:0]                      col;
  } fifo_entry_t;

endpackage

// File: rtl/conv_rlt_fifo.sv
// Synchronous FIFO for tagged window results, with a synchronous clear that drops its contents.
module conv_rlt_fifo #(
  parameter int width = 18,
  parameter int depth = 4
) (
  input  logic             clk_en,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_en) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < depth; i++) mem_q[i] <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/conv_rlt_collect.sv
// Multiply-accumulates kernel taps per output window, tags each sum with its raster
// position and hands it to the result writer through a small FIFO.
module conv_rlt_collect
  import conv_pkg::*;
#(
  parameter int weight_width  = DEF_WEIGHT_WIDTH,
  parameter int weight_height = DEF_WEIGHT_HEIGHT,
  parameter int result_width  = DEF_RESULT_WIDTH,
  parameter int result_height = DEF_RESULT_HEIGHT,
  parameter int bitwidth      = DEF_BITWIDTH,
  parameter int acc_width     = 2 * bitwidth + 4,
  parameter int fifo_depth    = DEF_FIFO_DEPTH
) (
  input  logic                 clk_en,
  input  logic                 rst_n,
  input  logic                 conv_on,
  input  logic                 tap_valid,
  output logic                 tap_ready,
  input  logic [bitwidth-1:0]  tap_pix,
  input  logic [bitwidth-1:0]  tap_wgt,
  input  logic                 tap_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [acc_width-1:0] out_data,
  output logic [3:0]           out_row,
  output logic [3:0]           out_col,
  output logic                 done,
  output logic                 err
);

  localparam int taps = weight_width * weight_height;
  localparam int TCW  = (taps > 1) ? $clog2(taps) : 1;
  localparam int FW   = acc_width + 8;

  state_e                 state_q, state_d;
  logic signed [acc_width-1:0] acc_q, acc_d, prod_ext, sum;
  logic [TCW-1:0]         tap_cnt_q, tap_cnt_d;
  logic [3:0]             row_q, row_d, col_q, col_d;
  logic                   err_q, err_d;

  logic signed [2*bitwidth-1:0] pix_ext, wgt_ext, prod;
  logic                   tap_fire, last_tap, push, last_res;
  logic                   fifo_full, fifo_empty;
  logic [FW-1:0]          fifo_rdata;

  assign pix_ext  = {{bitwidth{tap_pix[bitwidth-1]}}, tap_pix};
  assign wgt_ext  = {{bitwidth{tap_wgt[bitwidth-1]}}, tap_wgt};
  assign prod     = pix_ext * wgt_ext;
  assign prod_ext = {{(acc_width-2*bitwidth){prod[2*bitwidth-1]}}, prod};
  assign sum      = acc_q + prod_ext;

  assign tap_ready = (state_q == ACCUM) & ~fifo_full;
  assign tap_fire  = tap_valid & tap_ready;
  assign last_tap  = (tap_cnt_q == TCW'(taps - 1));
  assign push      = tap_fire & last_tap;
  assign last_res  = (row_q == 4'(result_height - 1)) && (col_q == 4'(result_width - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (conv_on) state_d = ACCUM;
      ACCUM: if (push && last_res) state_d = FLUSH;
      FLUSH: if (fifo_empty) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (!conv_on) state_d = IDLE;
  end

  always_comb begin
    acc_d     = acc_q;
    tap_cnt_d = tap_cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    err_d     = err_q;
    if (tap_fire) begin
      // Window framing follows tap_cnt alone; tap_last only feeds the sticky error.
      if (tap_last != last_tap) err_d = 1'b1;
      if (last_tap) begin
        acc_d     = '0;
        tap_cnt_d = '0;
        if (col_q == 4'(result_width - 1)) begin
          col_d = '0;
          row_d = row_q + 4'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end else begin
        acc_d     = sum;
        tap_cnt_d = tap_cnt_q + TCW'(1);
      end
    end
    if (!conv_on) begin
      acc_d     = '0;
      tap_cnt_d = '0;
      row_d     = '0;
      col_d     = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_en) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      tap_cnt_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      tap_cnt_q <= tap_cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      err_q     <= err_d;
    end
  end

  conv_rlt_fifo #(
    .width(FW),
    .depth(fifo_depth)
  ) u_fifo (
    .clk_en(clk_en),
    .rst_n (rst_n),
    .clear (~conv_on),
    .push  (push),
    .wdata ({sum, row_q, col_q}),
    .pop   (out_valid & out_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_rdata[FW-1:8];
  assign out_row   = fifo_rdata[7:4];
  assign out_col   = fifo_rdata[3:0];
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_conv_rlt_collect.sv
// Directed bench for conv_rlt_collect: 2x2 kernel, 3x3 result map, 3-bit taps, 4-entry FIFO.
module tb_conv_rlt_collect;

  logic       clk_en = 1'b0;
  logic       rst_n, conv_on, tap_valid, tap_last, out_ready;
  logic [2:0] tap_pix, tap_wgt;
  logic       tap_ready, out_valid, done, err;
  logic [9:0] out_data;
  logic [3:0] out_row, out_col;

  int checks = 0;
  int errors = 0;

  always #5 clk_en = ~clk_en;

  conv_rlt_collect #(
    .weight_width (2),
    .weight_height(2),
    .result_width (3),
    .result_height(3),
    .bitwidth     (3),
    .acc_width    (10),
    .fifo_depth   (4)
  ) dut (
    .clk_en   (clk_en),
    .rst_n    (rst_n),
    .conv_on  (conv_on),
    .tap_valid(tap_valid),
    .tap_ready(tap_ready),
    .tap_pix  (tap_pix),
    .tap_wgt  (tap_wgt),
    .tap_last (tap_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_row  (out_row),
    .out_col  (out_col),
    .done     (done),
    .err      (err)
  );

  task automatic tick();
    @(posedge clk_en);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_tap(input int pix, input int wgt, input bit last);
    int n;
    tap_valid = 1'b1;
    tap_pix   = pix[2:0];
    tap_wgt   = wgt[2:0];
    tap_last  = last;
    n = 0;
    while (!tap_ready && n < 50) begin
      tick();
      n++;
    end
    check("tap_ready_wait", tap_ready, 1);
    tick();
    tap_valid = 1'b0;
    tap_last  = 1'b0;
  endtask

  task automatic send_window(input int pix, input int wgt);
    for (int t = 0; t < 4; t++) send_tap(pix, wgt, t == 3);
  endtask

  task automatic restart();
    conv_on = 1'b0;
    tick();
    conv_on = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; conv_on = 1'b0; tap_valid = 1'b0; tap_last = 1'b0;
    tap_pix = '0; tap_wgt = '0; out_ready = 1'b1;
    tick();
    tick();
    check("rst_tap_ready", tap_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    rst_n = 1'b1; conv_on = 1'b1;
    tick();
    check("accum_tap_ready", tap_ready, 1);

    // 1: 1+2+3-1 = 5, visible right after the edge accepting the 4th tap
    send_tap(1, 1, 0);
    send_tap(2, 1, 0);
    send_tap(3, 1, 0);
    check("t1_no_early_valid", out_valid, 0);
    send_tap(-1, 1, 1);
    check("t1_valid", out_valid, 1);
    check("t1_data", $signed(out_data), 5);
    check("t1_row", out_row, 0);
    check("t1_col", out_col, 0);
    check("t1_err", err, 0);
    tick();
    check("t1_popped", out_valid, 0);

    // 2: full map, (-4)*(-4)*4 = 64 per window
    restart();
    for (int w = 0; w < 9; w++) begin
      send_window(-4, -4);
      check("t2_valid", out_valid, 1);
      check("t2_data", $signed(out_data), 64);
      check("t2_row", out_row, w / 3);
      check("t2_col", out_col, w % 3);
    end
    check("t2_flush_tap_ready", tap_ready, 0);
    check("t2_not_done_yet", done, 0);
    tick();
    check("t2_last_pop", out_valid, 0);
    check("t2_done_early", done, 0);
    tick();
    check("t2_done", done, 1);
    check("t2_done_tap_ready", tap_ready, 0);

    // 3: writer stalled, FIFO fills after four windows
    out_ready = 1'b0;
    restart();
    for (int w = 0; w < 4; w++) send_window(1, 1);
    check("t3_full_tap_ready", tap_ready, 0);
    check("t3_head_valid", out_valid, 1);
    check("t3_head_data", $signed(out_data), 4);
    check("t3_head_row", out_row, 0);
    check("t3_head_col", out_col, 0);
    tick();
    tick();
    check("t3_hold_col", out_col, 0);
    check("t3_hold_ready", tap_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_pop_tap_ready", tap_ready, 1);
    check("t3_next_col", out_col, 1);
    check("t3_next_row", out_row, 0);

    // 4: tap_last early on tap 2 and missing on tap 4; 4*(1*2) = 8
    out_ready = 1'b1;
    restart();
    check("t4_err_cleared", err, 0);
    send_tap(1, 2, 0);
    send_tap(1, 2, 1);
    check("t4_err_set", err, 1);
    send_tap(1, 2, 0);
    send_tap(1, 2, 0);
    check("t4_err_sticky", err, 1);
    check("t4_valid", out_valid, 1);
    check("t4_data", $signed(out_data), 8);
    check("t4_col", out_col, 0);

    // 5: three windows buffered, conv_on dropped for one cycle
    out_ready = 1'b0;
    send_window(1, 1);
    send_window(1, 1);
    check("t5_pre_valid", out_valid, 1);
    conv_on = 1'b0;
    tick();
    check("t5_flushed", out_valid, 0);
    check("t5_err_clear", err, 0);
    check("t5_idle_tap_ready", tap_ready, 0);
    conv_on = 1'b1; out_ready = 1'b1;
    tick();
    send_window(2, 3);
    check("t5_data", $signed(out_data), 24);
    check("t5_row", out_row, 0);
    check("t5_col", out_col, 0);

    // 6: reset halfway through a window with a tap still offered
    send_tap(3, 3, 0);
    send_tap(3, 3, 0);
    rst_n = 1'b0; tap_valid = 1'b1; tap_pix = 3'd3; tap_wgt = 3'd3;
    tick();
    check("t6_tap_ready", tap_ready, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_data", $signed(out_data), 0);
    check("t6_out_row", out_row, 0);
    check("t6_out_col", out_col, 0);
    check("t6_done", done, 0);
    check("t6_err", err, 0);
    tap_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    send_window(1, -1);
    check("t6_data", $signed(out_data), -4);
    check("t6_row", out_row, 0);
    check("t6_col", out_col, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
